// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam int          PC_STEP    = 4;
    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

endpackage

// File: rtl/dff.sv
// Plain N-bit register with asynchronous active-high reset to zero.
// Latency: one edge from d to q. No handshake.
module dff #(
    parameter int N = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) q <= '0;
        else       q <= d;
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, drives imem_addr, captures words into a valid/ready slot.
// Latency: word at PC appears on out_* one edge later; a full slot stalls the PC until out_ready.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clock,
    input  logic         reset,
    output logic [N-1:0] imem_addr,
    input  logic [N-1:0] imem_data,
    input  logic         redirect,
    input  logic [N-1:0] redirect_pc,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [N-1:0] out_instr,
    output logic [N-1:0] out_pc,
    output logic [N-1:0] out_pc4
);

    fetch_state_t state, state_nxt;
    logic [N-1:0] pc, pc_nxt, pc_q, redirect_tgt;
    logic         load, accept, is_halt;

    // The register resets to zero, so store the PC offset from RESET_PC.
    dff #(.N(N)) u_pc (
        .clock (clock),
        .reset (reset),
        .d     (pc_nxt ^ RESET_PC),
        .q     (pc_q)
    );

    assign pc           = pc_q ^ RESET_PC;
    assign imem_addr    = pc;
    assign redirect_tgt = redirect_pc & ~{{(N-2){1'b0}}, 2'b11};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= BOOT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        accept    = out_valid & out_ready;
        is_halt   = (imem_data == N'(HALT_INSTR));
        load      = (state == RUN) && (!out_valid || out_ready) && !redirect;

        case (state)
            BOOT:    state_nxt = RUN;
            RUN:     if (load && is_halt) state_nxt = HALT;
            HALT:    state_nxt = HALT;
            default: state_nxt = BOOT;
        endcase

        if (redirect) begin
            pc_nxt = redirect_tgt;
            if (state != BOOT) state_nxt = RUN;
        end else if (load && !is_halt) begin
            pc_nxt = pc + N'(PC_STEP);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
            out_pc4   <= '0;
        end else if (redirect && state != BOOT) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_instr <= imem_data;
            out_pc    <= pc;
            out_pc4   <= pc + N'(PC_STEP);
        end else if (state == HALT && accept) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scenarios followed by random traffic, all checked against a transaction-level model.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] imem_addr, imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_instr, out_pc, out_pc4;

    logic [31:0] base;
    logic [31:0] halt_addr;

    int checks   = 0;
    int failures = 0;

    // reference model state
    bit          m_boot, m_halt, m_valid;
    logic [31:0] m_pc, m_instr, m_opc, m_pc4;

    fetch_unit #(.N(32), .RESET_PC(32'h0)) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_pc4     (out_pc4)
    );

    always #5 clock = ~clock;

    assign imem_data = (imem_addr == halt_addr) ? 32'hFFFF_FFFF : (base | imem_addr);

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == halt_addr) ? 32'hFFFF_FFFF : (base | a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_boot = 1; m_halt = 0; m_valid = 0;
        m_pc = 32'h0; m_instr = 0; m_opc = 0; m_pc4 = 0;
    endtask

    // One clock edge of architectural behaviour, evaluated on the inputs present before the edge.
    task automatic model_edge();
        logic [31:0] w;
        if (m_boot) begin
            m_boot = 0;
            if (redirect) m_pc = {redirect_pc[31:2], 2'b00};
        end else if (redirect) begin
            m_pc = {redirect_pc[31:2], 2'b00};
            m_valid = 0;
            m_halt = 0;
        end else if (m_halt) begin
            if (m_valid && out_ready) m_valid = 0;
        end else if (!m_valid || out_ready) begin
            w = mem(m_pc);
            m_instr = w; m_opc = m_pc; m_pc4 = m_pc + 32'd4; m_valid = 1;
            if (w == 32'hFFFF_FFFF) m_halt = 1;
            else                    m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic compare_all();
        check("imem_addr", imem_addr, m_pc);
        check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        check("out_instr", out_instr, m_instr);
        check("out_pc",    out_pc,    m_opc);
        check("out_pc4",   out_pc4,   m_pc4);
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    initial begin
        reset = 1; redirect = 0; redirect_pc = 0; out_ready = 1;
        base = 32'h1000_0000; halt_addr = 32'h0000_0001;
        model_reset();
        #1;
        compare_all();
        @(posedge clock); #1;
        reset = 0;

        // 1: boot then streaming fetch
        step();
        check("boot_valid", {31'b0, out_valid}, 32'd0);
        step();
        check("first_pc", out_pc, 32'h0);
        check("first_instr", out_instr, 32'h1000_0000);
        step();
        check("seq_pc4", out_pc, 32'h4);
        step();
        check("seq_pc8", out_pc, 32'h8);

        // 2: stall
        out_ready = 0;
        repeat (3) begin
            step();
            check("stall_pc", out_pc, 32'h8);
            check("stall_addr", imem_addr, 32'hC);
        end
        out_ready = 1;
        step();
        check("unstall_pc", out_pc, 32'hC);

        // 3: redirect while stalled
        out_ready = 0; redirect = 1; redirect_pc = 32'h0000_0103;
        step();
        check("redir_valid", {31'b0, out_valid}, 32'd0);
        check("redir_addr", imem_addr, 32'h100);
        redirect = 0; out_ready = 1;
        step();
        check("redir_pc", out_pc, 32'h100);
        check("redir_pc4", out_pc4, 32'h104);

        // 4: halt at 0x10
        halt_addr = 32'h10; redirect = 1; redirect_pc = 32'h10;
        step();
        redirect = 0;
        step();
        check("halt_instr", out_instr, 32'hFFFF_FFFF);
        check("halt_pc", out_pc, 32'h10);
        step();
        check("halt_drain", {31'b0, out_valid}, 32'd0);
        step();
        check("halt_hold", imem_addr, 32'h10);
        redirect = 1; redirect_pc = 32'h40;
        step();
        redirect = 0;
        step();
        check("unhalt_pc", out_pc, 32'h40);

        // 5: wrap
        redirect = 1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 0;
        step();
        check("wrap_pc", out_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", out_pc4, 32'h0);
        step();
        check("wrap_next", out_pc, 32'h0);

        // 6: reset mid-stall, between edges
        out_ready = 0;
        step();
        step();
        #2 reset = 1;
        model_reset();
        #1;
        compare_all();
        @(posedge clock); #1;
        reset = 0;
        out_ready = 1;
        step();
        step();
        check("rst_refetch_pc", out_pc, 32'h0);
        check("rst_refetch_vld", {31'b0, out_valid}, 32'd1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            out_ready   = ($urandom_range(3) != 0);
            redirect    = ($urandom_range(9) == 0);
            redirect_pc = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(15))
                                                   : $urandom;
            base        = {$urandom_range(255), 24'h0};
            if ($urandom_range(15) == 0) halt_addr = m_pc + 32'($urandom_range(3) * 4);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
